global_avgpool_4x4_128ch_reader: RTL

GLOBAL_AVGPOOL_4X4_128CH_READER -- requirements
Module: global_avgpool_4x4_128ch_reader

---
 rtl/global_avgpool_4x4_128ch_reader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/global_avgpool_4x4_128ch_reader.sv
// Streams the upstream 4x4 pooled maps one element per cycle and stores a
// truncated per-channel average, readable with one cycle of latency.
module global_avgpool_4x4_128ch_reader #(
  parameter int unsigned CHANNELS    = 128,
  parameter int unsigned VALS_PER_CH = 16,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [4:0]  input_image_index,
  output logic        up_start,
  output logic [4:0]  up_image_index,
  input  logic        up_done,
  output logic [31:0] up_read_addr,
  input  logic [3:0]  up_read_data,
  input  logic [6:0]  read_addr,
  output logic [3:0]  read_data,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TOTAL  = CHANNELS * VALS_PER_CH;
  localparam int unsigned VSHIFT = $clog2(VALS_PER_CH);
  localparam int unsigned CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W  = $clog2(TOTAL);
  localparam int unsigned ACC_W  = 4 + VSHIFT;

  localparam logic [31:0]       LAST_ADDR = 32'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  LAST_SMP  = CNT_W'(TOTAL - 1);
  localparam logic [VSHIFT-1:0] LAST_IDX  = VSHIFT'(VALS_PER_CH - 1);
  localparam logic [7:0]        CH_LIM    = 8'(CHANNELS);

  typedef enum logic [2:0] {
    IDLE,
    UP_START,
    WAIT_UP,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [READ_LAT-1:0] tag, tag_next;
  logic [CNT_W-1:0]    smp_cnt;
  logic [ACC_W-1:0]    acc, sum;
  logic [VSHIFT-1:0]   smp_idx;
  logic [CW-1:0]       smp_ch;
  logic                issue, up_go, sample_valid;
  logic [3:0]          result [CHANNELS];

  // Samples are consumed in issue order, so a count of consumed samples
  // identifies channel and position without carrying addresses in the tags.
  always_comb begin
    issue        = (state == STREAM);
    up_go        = (state == WAIT_UP) && up_done;
    sample_valid = tag[READ_LAT-1];
    smp_idx      = smp_cnt[VSHIFT-1:0];
    smp_ch       = CW'(smp_cnt >> VSHIFT);
    sum          = ((smp_idx == '0) ? '0 : acc) + ACC_W'(up_read_data);
    tag_next     = '0;
    tag_next[0]  = issue;
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      tag_next[i] = tag[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    up_start   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = UP_START;
        end
      end
      UP_START: begin
        up_start   = 1'b1;
        state_next = WAIT_UP;
      end
      WAIT_UP: begin
        if (up_done) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (up_read_addr == LAST_ADDR) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (sample_valid && (smp_cnt == LAST_SMP)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      up_image_index <= '0;
      up_read_addr   <= '0;
      tag            <= '0;
      smp_cnt        <= '0;
      acc            <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        up_image_index <= input_image_index;
      end
      if (up_go) begin
        up_read_addr <= '0;
        tag          <= '0;
        smp_cnt      <= '0;
      end else begin
        tag <= tag_next;
        if (issue && (up_read_addr != LAST_ADDR)) begin
          up_read_addr <= up_read_addr + 32'd1;
        end
        if (sample_valid) begin
          smp_cnt <= smp_cnt + 1'b1;
          acc     <= sum;
        end
      end
    end
  end

  // Result storage is deliberately left out of reset so earlier results survive.
  always_ff @(posedge clk) begin
    if (sample_valid && (smp_idx == LAST_IDX)) begin
      result[smp_ch] <= sum[ACC_W-1:VSHIFT];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      read_data <= '0;
    end else if ({1'b0, read_addr} < CH_LIM) begin
      read_data <= result[read_addr[CW-1:0]];
    end else begin
      read_data <= '0;
    end
  end

endmodule
